// File: rtl/pipelined_mult_unit.sv
// Pipelined RV32M/RV64M multiply unit with a valid/ready handshake, stall and flush.
// Build option: MULT_OUT_REG_EN adds one output register after the last stage (latency STAGES+1).
module pipelined_mult_unit #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned STAGES = 3,
  parameter int unsigned TAG_W  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag
);

`ifdef MULT_OUT_REG_EN
  localparam int unsigned OUT_REG = 1;
`else
  localparam int unsigned OUT_REG = 0;
`endif
  localparam int unsigned DEPTH = STAGES + OUT_REG;
  localparam int unsigned PW    = 2 * XLEN;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  logic                    a_sgn_c;
  logic                    b_sgn_c;
  logic signed [XLEN:0]    a_ext_c;
  logic signed [XLEN:0]    b_ext_c;
  logic        [PW-1:0]    prod_c;
  logic        [XLEN-1:0]  result_c;
  logic                    stall_c;
  logic                    accept_c;

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [XLEN-1:0]  res_q [DEPTH];
  logic [XLEN-1:0]  res_d [DEPTH];
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic [TAG_W-1:0] tag_d [DEPTH];

  // Operand extension to XLEN+1 bits, then product modulo 2^(2*XLEN); the two
  // extra top bits of the full signed product never reach the result.
  always_comb begin
    a_sgn_c  = (in_op == OP_MULH) || (in_op == OP_MULHSU);
    b_sgn_c  = (in_op == OP_MULH);
    a_ext_c  = {a_sgn_c & in_a[XLEN-1], in_a};
    b_ext_c  = {b_sgn_c & in_b[XLEN-1], in_b};
    prod_c   = PW'(a_ext_c) * PW'(b_ext_c);
    result_c = (in_op == OP_MUL) ? prod_c[XLEN-1:0] : prod_c[PW-1:XLEN];
  end

  // Whole pipe holds while the head result waits; flush blocks new issue.
  always_comb begin
    stall_c  = vld_q[DEPTH-1] && !out_ready;
    in_ready = !stall_c && !flush;
    accept_c = in_valid && in_ready;
  end

  // Valid shift chain with data/tag alongside; flush wins over stall.
  always_comb begin
    vld_d = vld_q;
    res_d = res_q;
    tag_d = tag_q;
    if (flush) begin
      vld_d = '0;
    end else if (!stall_c) begin
      vld_d[0] = accept_c;
      if (accept_c) begin
        res_d[0] = result_c;
        tag_d[0] = in_tag;
      end
      for (int i = 1; i < int'(DEPTH); i++) begin
        vld_d[i] = vld_q[i-1];
        res_d[i] = res_q[i-1];
        tag_d[i] = tag_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        res_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < int'(DEPTH); i++) begin
        res_q[i] <= res_d[i];
        tag_q[i] <= tag_d[i];
      end
    end
  end

  always_comb begin
    out_valid  = vld_q[DEPTH-1];
    out_result = res_q[DEPTH-1];
    out_tag    = tag_q[DEPTH-1];
  end

endmodule

// File: tb/tb_pipelined_mult_unit.sv
// Self-checking bench for pipelined_mult_unit: directed vector table, handshake corner
// sequences and randomized traffic checked against a transaction-level reference model.
module tb_pipelined_mult_unit;

`ifdef MULT_OUT_REG_EN
  localparam int STG = 1;
  localparam int LAT = 2;
`else
  localparam int STG = 3;
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [5:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [5:0]  out_tag;

  pipelined_mult_unit #(.XLEN(32), .STAGES(STG), .TAG_W(6)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  tag;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [5:0]  tag;
    int          t;
  } exp_t;

  vec_t tbl [12];
  exp_t q [$];
  int   adv;
  int   nvec;
  int   nerr;

  // Reference: plain 64-bit arithmetic on the architectural operand interpretation.
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      2'd1:    p = sa * sb;
      2'd2:    p = sa * longint'(ub);
      default: p = ua * ub;
    endcase
    return (op == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs after a falling edge, check visible state, advance the model.
  task automatic cycle(input logic v, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [5:0] tag, input logic [31:0] ex,
                       input logic ordy, input logic fl);
    logic ev;
    logic er;
    exp_t e;
    in_valid  = v;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    in_tag    = tag;
    out_ready = ordy;
    flush     = fl;
    #1;
    ev = 1'b0;
    if (q.size() > 0) ev = (adv >= q[0].t + LAT);
    chk("out_valid", 64'(out_valid), 64'(ev));
    if (ev) begin
      chk("out_result", 64'(out_result), 64'(q[0].res));
      chk("out_tag", 64'(out_tag), 64'(q[0].tag));
    end
    er = !(ev && !ordy) && !fl;
    chk("in_ready", 64'(in_ready), 64'(er));
    if (fl) begin
      q.delete();
    end else if (er) begin
      if (ev) void'(q.pop_front());
      if (v) begin
        e.res = ex;
        e.tag = tag;
        e.t   = adv;
        q.push_back(e);
      end
      adv++;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, 32'd0, 32'd0, 6'd0, 32'd0, ordy, 1'b0);
  endtask

  task automatic issue(input vec_t v, input logic ordy);
    cycle(1'b1, v.op, v.a, v.b, v.tag, v.exp, ordy, 1'b0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    vec_t rv;
    nvec = 0;
    nerr = 0;
    adv  = 0;
    tbl[0]  = '{2'd0, 32'd7,         32'hFFFF_FFFD, 6'd5,  32'hFFFF_FFEB};
    tbl[1]  = '{2'd1, 32'h8000_0000, 32'h8000_0000, 6'd1,  32'h4000_0000};
    tbl[2]  = '{2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd2,  32'hFFFF_FFFF};
    tbl[3]  = '{2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd3,  32'hFFFF_FFFE};
    tbl[4]  = '{2'd0, 32'hFFFF_FFFF, 32'd2,         6'd4,  32'hFFFF_FFFE};
    tbl[5]  = '{2'd1, 32'd7,         32'hFFFF_FFFD, 6'd6,  32'hFFFF_FFFF};
    tbl[6]  = '{2'd3, 32'h8000_0000, 32'd2,         6'd7,  32'h0000_0001};
    tbl[7]  = '{2'd2, 32'h8000_0000, 32'h8000_0000, 6'd8,  32'hC000_0000};
    tbl[8]  = '{2'd0, 32'h1234_5678, 32'd0,         6'd9,  32'h0000_0000};
    tbl[9]  = '{2'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 6'd10, 32'h3FFF_FFFF};
    tbl[10] = '{2'd1, 32'h8000_0000, 32'h7FFF_FFFF, 6'd11, 32'hC000_0000};
    tbl[11] = '{2'd0, 32'd2,         32'd3,         6'd12, 32'h0000_0006};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = 2'd0;
    in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_result", 64'(out_result), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    rst = 1'b0;

    // Single MUL: exact latency, then the whole table back to back.
    issue(tbl[0], 1'b1);
    idle(LAT + 2, 1'b1);
    for (int i = 1; i < 12; i++) issue(tbl[i], 1'b1);
    idle(LAT + 2, 1'b1);

    // Three in flight, consumer stalls; offered ops are refused while stalled.
    for (int i = 1; i < 4; i++) issue(tbl[i], 1'b1);
    for (int i = 0; i < LAT + 4; i++) begin
      rv = tbl[5 + (i % 5)];
      cycle(1'b1, rv.op, rv.a, rv.b, rv.tag, rv.exp, 1'b0, 1'b0);
    end
    idle(LAT + 8, 1'b1);

    // Flush with two ops in flight while another op is presented.
    issue(tbl[4], 1'b1);
    issue(tbl[5], 1'b1);
    cycle(1'b1, tbl[6].op, tbl[6].a, tbl[6].b, tbl[6].tag, tbl[6].exp, 1'b1, 1'b1);
    idle(LAT + 3, 1'b1);

    // Flush overriding a stall with a valid result at the output.
    issue(tbl[7], 1'b1);
    idle(LAT + 1, 1'b0);
    cycle(1'b0, 2'd0, 32'd0, 32'd0, 6'd0, 32'd0, 1'b0, 1'b1);
    idle(LAT + 2, 1'b1);

    // Asynchronous reset with a stalled result showing.
    issue(tbl[9], 1'b1);
    issue(tbl[10], 1'b1);
    idle(LAT + 1, 1'b0);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_result", 64'(out_result), 64'd0);
    chk("async_rst_tag", 64'(out_tag), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    adv = 0;
    issue(tbl[11], 1'b1);
    idle(LAT + 2, 1'b1);

    // Randomized traffic with corner-biased operands, random backpressure and flushes.
    for (int i = 0; i < 600; i++) begin
      rv.op  = 2'($urandom_range(0, 3));
      rv.a   = pick();
      rv.b   = pick();
      rv.tag = 6'($urandom);
      rv.exp = ref_mul(rv.op, rv.a, rv.b);
      cycle($urandom_range(0, 9) < 7, rv.op, rv.a, rv.b, rv.tag, rv.exp,
            $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0);
    end
    idle(LAT + 4, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
